// File: rtl/m_axis_burst_sequencer.sv
// AXI-Stream burst generator: emits cfg_bursts bursts of cfg_len incrementing beats
// starting at cfg_seed, separated by cfg_gap idle cycles; abort stops at a burst boundary.
module m_axis_burst_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_seed,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [LEN_W-1:0]  cfg_gap,
    input  logic [LEN_W-1:0]  cfg_bursts,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  burst_idx
);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  data_q;
    logic               tvalid_q;
    logic               tlast_q;
    logic               busy_q;
    logic               done_q;
    logic               abort_q;
    logic [LEN_W-1:0]   burst_idx_q;
    logic [LEN_W-1:0]   beat_q;
    logic [LEN_W-1:0]   gap_cnt_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   gap_q;
    logic [LEN_W-1:0]   bursts_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            data_q      <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            burst_idx_q <= '0;
            beat_q      <= '0;
            gap_cnt_q   <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            bursts_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // abort arriving together with start is deliberately dropped
                    if (start && (cfg_len != '0) && (cfg_bursts != '0)) begin
                        len_q       <= cfg_len;
                        gap_q       <= cfg_gap;
                        bursts_q    <= cfg_bursts;
                        data_q      <= cfg_seed;
                        tvalid_q    <= 1'b1;
                        tlast_q     <= (cfg_len == LEN_W'(1));
                        beat_q      <= LEN_W'(1);
                        burst_idx_q <= '0;
                        abort_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    if (abort) abort_q <= 1'b1;
                    if (tvalid_q && m_axis_tready) begin
                        data_q <= data_q + DATA_W'(1);
                        if (tlast_q) begin
                            if ((burst_idx_q == bursts_q - LEN_W'(1)) || abort_q || abort) begin
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                state_q  <= IDLE;
                            end else begin
                                burst_idx_q <= burst_idx_q + LEN_W'(1);
                                beat_q      <= LEN_W'(1);
                                if (gap_q == '0) begin
                                    tlast_q <= (len_q == LEN_W'(1));
                                end else begin
                                    tvalid_q  <= 1'b0;
                                    tlast_q   <= 1'b0;
                                    gap_cnt_q <= gap_q;
                                    state_q   <= GAP;
                                end
                            end
                        end else begin
                            beat_q  <= beat_q + LEN_W'(1);
                            tlast_q <= (beat_q + LEN_W'(1) == len_q);
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (gap_cnt_q == LEN_W'(1)) begin
                        tvalid_q <= 1'b1;
                        tlast_q  <= (len_q == LEN_W'(1));
                        state_q  <= BURST;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - LEN_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign burst_idx     = burst_idx_q;

endmodule

// File: tb/tb_m_axis_burst_sequencer.sv
// Directed bench for m_axis_burst_sequencer with hand-computed expected beats.
module tb_m_axis_burst_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    logic        abort;
    logic [31:0] cfg_seed;
    logic [15:0] cfg_len;
    logic [15:0] cfg_gap;
    logic [15:0] cfg_bursts;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic [15:0] burst_idx;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 aclk = ~aclk;

    m_axis_burst_sequencer #(.DATA_W(32), .LEN_W(16)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .abort         (abort),
        .cfg_seed      (cfg_seed),
        .cfg_len       (cfg_len),
        .cfg_gap       (cfg_gap),
        .cfg_bursts    (cfg_bursts),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .burst_idx     (burst_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_seq(input logic [31:0] seed, input logic [15:0] len,
                             input logic [15:0] gap, input logic [15:0] bursts,
                             input logic ab);
        cfg_seed   = seed;
        cfg_len    = len;
        cfg_gap    = gap;
        cfg_bursts = bursts;
        start      = 1'b1;
        abort      = ab;
        step();
        start      = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'd0, m_axis_tvalid}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},          32'd0);
        check({tag, "_done"},  {31'd0, done},          32'd0);
    endtask

    initial begin
        logic [15:0] rdy_pat;
        logic [31:0] exp_d;
        int unsigned acc;
        int unsigned beat;
        int unsigned done_cnt;
        bit          ev;

        aresetn = 1'b0; start = 1'b0; abort = 1'b0; m_axis_tready = 1'b1;
        cfg_seed = '0; cfg_len = '0; cfg_gap = '0; cfg_bursts = '0;
        step(); step();
        check("rst_valid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_last",  {31'd0, m_axis_tlast},  32'd0);
        check("rst_data",  m_axis_tdata,           32'd0);
        check("rst_busy",  {31'd0, busy},          32'd0);
        check("rst_done",  {31'd0, done},          32'd0);
        check("rst_idx",   {16'd0, burst_idx},     32'd0);
        aresetn = 1'b1;
        step();

        // seed 100, len 4, gap 3, 2 bursts; abort with start ignored; restart and cfg changes ignored
        start_seq(32'd100, 16'd4, 16'd3, 16'd2, 1'b1);
        done_cnt = 0;
        for (int c = 0; c < 13; c++) begin
            ev = (c <= 3) || (c >= 7 && c <= 10);
            check("b2_valid", {31'd0, m_axis_tvalid}, {31'd0, ev});
            if (ev) begin
                check("b2_data", m_axis_tdata, (c <= 3) ? 32'(100 + c) : 32'(104 + c - 7));
                check("b2_last", {31'd0, m_axis_tlast}, {31'd0, (c == 3 || c == 10)});
            end
            check("b2_done", {31'd0, done}, {31'd0, (c == 11)});
            if (done) done_cnt++;
            if (c == 0) check("b2_idx0", {16'd0, burst_idx}, 32'd0);
            if (c == 0) check("b2_busy", {31'd0, busy}, 32'd1);
            if (c == 8) check("b2_idx1", {16'd0, burst_idx}, 32'd1);
            if (c == 0) begin
                cfg_seed = 32'd999; cfg_len = 16'd1; cfg_gap = 16'd0; cfg_bursts = 16'd9;
            end
            start = (c == 5);
            step();
        end
        start = 1'b0;
        check("b2_donecnt", done_cnt, 32'd1);
        check("b2_idxhold", {16'd0, burst_idx}, 32'd1);
        check_idle("b2_end");

        // wrap from all-ones
        start_seq(32'hFFFF_FFFE, 16'd4, 16'd0, 16'd1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("wr_valid", {31'd0, m_axis_tvalid}, {31'd0, (c < 4)});
            if (c < 4) begin
                check("wr_data", m_axis_tdata, 32'hFFFF_FFFE + 32'(c));
                check("wr_last", {31'd0, m_axis_tlast}, {31'd0, (c == 3)});
            end
            check("wr_done", {31'd0, done}, {31'd0, (c == 4)});
            step();
        end

        // len 1: tlast on every beat, back-to-back bursts
        start_seq(32'd7, 16'd1, 16'd0, 16'd2, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check("l1_valid", {31'd0, m_axis_tvalid}, {31'd0, (c < 2)});
            if (c < 2) begin
                check("l1_data", m_axis_tdata, 32'(7 + c));
                check("l1_last", {31'd0, m_axis_tlast}, 32'd1);
            end
            check("l1_done", {31'd0, done}, {31'd0, (c == 2)});
            step();
        end

        // backpressure: len 5, 3 bursts, gap 0, fixed ready pattern
        rdy_pat = 16'b1011_0010_1101_0110;
        start_seq(32'd200, 16'd5, 16'd0, 16'd3, 1'b0);
        acc = 0; beat = 1; exp_d = 32'd200;
        for (int cyc = 0; cyc < 200 && acc < 15; cyc++) begin
            check("bp_valid", {31'd0, m_axis_tvalid}, 32'd1);
            check("bp_data", m_axis_tdata, exp_d);
            check("bp_last", {31'd0, m_axis_tlast}, {31'd0, (beat == 5)});
            check("bp_done", {31'd0, done}, 32'd0);
            m_axis_tready = rdy_pat[cyc % 16];
            step();
            if (m_axis_tready) begin
                acc++;
                exp_d++;
                beat = (beat == 5) ? 1 : beat + 1;
            end
        end
        m_axis_tready = 1'b1;
        check("bp_count", acc, 32'd15);
        check("bp_end_done", {31'd0, done}, 32'd1);
        check("bp_end_valid", {31'd0, m_axis_tvalid}, 32'd0);
        check("bp_end_idx", {16'd0, burst_idx}, 32'd2);
        step();

        // abort during beat 3 of burst 0: burst completes, nothing follows
        start_seq(32'd0, 16'd8, 16'd2, 16'd4, 1'b0);
        for (int c = 0; c < 12; c++) begin
            check("ab_valid", {31'd0, m_axis_tvalid}, {31'd0, (c <= 7)});
            if (c <= 7) begin
                check("ab_data", m_axis_tdata, 32'(c));
                check("ab_last", {31'd0, m_axis_tlast}, {31'd0, (c == 7)});
            end
            check("ab_done", {31'd0, done}, {31'd0, (c == 8)});
            abort = (c == 2);
            step();
        end
        abort = 1'b0;
        check("ab_idx", {16'd0, burst_idx}, 32'd0);

        // abort while in GAP ends the sequence on the next cycle
        start_seq(32'd10, 16'd2, 16'd4, 16'd3, 1'b0);
        for (int c = 0; c < 7; c++) begin
            check("ag_valid", {31'd0, m_axis_tvalid}, {31'd0, (c <= 1)});
            if (c <= 1) check("ag_data", m_axis_tdata, 32'(10 + c));
            check("ag_busy", {31'd0, busy}, {31'd0, (c <= 3)});
            check("ag_done", {31'd0, done}, {31'd0, (c == 4)});
            abort = (c == 3);
            step();
        end
        abort = 1'b0;
        check("ag_idx", {16'd0, burst_idx}, 32'd1);

        // zero length or zero burst count is ignored
        start_seq(32'd5, 16'd0, 16'd0, 16'd3, 1'b0);
        check_idle("z_len");
        step();
        check_idle("z_len2");
        start_seq(32'd5, 16'd4, 16'd0, 16'd0, 1'b0);
        check_idle("z_bur");
        step();
        check_idle("z_bur2");

        // async reset in the middle of burst 1
        start_seq(32'd50, 16'd3, 16'd1, 16'd3, 1'b0);
        for (int c = 0; c < 5; c++) step();
        check("rs_pre_data", m_axis_tdata, 32'd54);
        check("rs_pre_idx", {16'd0, burst_idx}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("rs_valid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rs_last",  {31'd0, m_axis_tlast},  32'd0);
        check("rs_data",  m_axis_tdata,           32'd0);
        check("rs_busy",  {31'd0, busy},          32'd0);
        check("rs_idx",   {16'd0, burst_idx},     32'd0);
        check("rs_done",  {31'd0, done},          32'd0);
        step(); step();
        aresetn = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) done_cnt++;
            step();
        end
        check("rs_nodone", done_cnt, 32'd0);
        start_seq(32'd1, 16'd0, 16'd0, 16'd3, 1'b0);
        check_idle("rs_zlen");
        step();
        check_idle("rs_zlen2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/m_axis_burst_sequencer.md
M_AXIS_BURST_SEQUENCER -- requirements
Module: m_axis_burst_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: tdata width and counter width.
REQ-002 Parameter LEN_W, default 16: width of beats-per-burst, gap and burst-count fields.
REQ-003 Port aclk, input, 1: single clock; all logic rising-edge.
REQ-004 Port aresetn, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: one-cycle request to begin a sequence.
REQ-006 Port abort, input, 1: request to stop at the next burst boundary.
REQ-007 Port cfg_seed, input, DATA_W: first tdata value of the sequence.
REQ-008 Port cfg_len, input, LEN_W: beats per burst.
REQ-009 Port cfg_gap, input, LEN_W: idle cycles between bursts.
REQ-010 Port cfg_bursts, input, LEN_W: number of bursts in the sequence.
REQ-011 Port m_axis_tdata, output, DATA_W: counter value.
REQ-012 Port m_axis_tvalid, output, 1: beat valid.
REQ-013 Port m_axis_tready, input, 1: downstream ready.
REQ-014 Port m_axis_tlast, output, 1: last beat of a burst.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle completion pulse.
REQ-017 Port burst_idx, output, LEN_W: zero-based index of the current burst.

Function
REQ-018 The FSM SHALL have states IDLE, BURST, GAP; all outputs SHALL be registered.
REQ-019 In IDLE, start=1 with cfg_len!=0 and cfg_bursts!=0 SHALL latch all cfg_* inputs and enter BURST next cycle; the first beat (tvalid=1, tdata=cfg_seed) SHALL appear the cycle after start.
REQ-020 start with cfg_len=0 or cfg_bursts=0 SHALL be ignored; the block stays in IDLE and done stays 0.
REQ-021 start outside IDLE and cfg_* changes after latching SHALL have no effect.
REQ-022 A beat SHALL be accepted only when tvalid=1 and tready=1; tdata, tlast and tvalid SHALL NOT change while tvalid=1 and tready=0.
REQ-023 tvalid SHALL NOT depend combinationally on tready and SHALL NOT deassert before acceptance.
REQ-024 tdata SHALL increment by 1 per accepted beat, continue across bursts without reloading, and wrap modulo 2^DATA_W (all-ones to 0).
REQ-025 tlast SHALL be 1 exactly on beat cfg_len of each burst; cfg_len=1 gives tlast on every beat.
REQ-026 On accepted tlast: if this was burst cfg_bursts-1 or abort is pending, the FSM SHALL go to IDLE with done=1 for one cycle; otherwise burst_idx SHALL increment and the FSM SHALL go to GAP, or directly to BURST when cfg_gap=0.
REQ-027 cfg_gap=0 SHALL yield back-to-back bursts, with tvalid continuously high if tready is held high.
REQ-028 GAP SHALL hold tvalid=0 for exactly cfg_gap cycles, then enter BURST.
REQ-029 abort SHALL be sticky until the sequence ends; it SHALL never truncate a burst, and abort in GAP SHALL end the sequence immediately, returning to IDLE with done=1 next cycle.
REQ-030 abort and start in the same IDLE cycle SHALL start the sequence and ignore the abort.
REQ-031 burst_idx SHALL hold its final value in IDLE until the next accepted start clears it to 0.

Reset
REQ-032 While aresetn=0, outputs SHALL be: tvalid=0, tlast=0, tdata=0, busy=0, done=0, burst_idx=0; the FSM SHALL be in IDLE.
REQ-033 Reset asserted mid-burst or mid-gap SHALL clear immediately without completing the burst; start SHALL be ignored until the first clock edge after deassertion.

Verification
REQ-034 Seed=100, len=4, bursts=2, gap=3, tready=1: beats 100..103 with tlast on 103, then 3 idle cycles, then 104..107 with tlast on 107; done pulses once; burst_idx goes 0 then 1.
REQ-035 Seed=0xFFFFFFFE, len=4, bursts=1: tdata FFFFFFFE, FFFFFFFF, 0, 1 with tlast on 1.
REQ-036 Random tready backpressure, len=5, bursts=3, gap=0: tdata and tlast stable while stalled; exactly 15 beats accepted, in order, with no gaps in the data sequence.
REQ-037 len=8, bursts=4, abort pulsed at beat 3 of burst 0: burst 0 completes all 8 beats, no further bursts follow, done=1, burst_idx=0.
REQ-038 Reset pulsed during burst 1 of a 3-burst sequence: all outputs return to 0 immediately and no done pulse occurs; a later start with len=0 is ignored.
